stage_id_pipe: RTL and testbench
================================

// Module: stage_id_pipe
// PURPOSE
//  Registered instruction-decode stage with N-channel operand forwarding, load-use hazard stall,
//  valid/ready handshakes on both sides and flush. Sits between IF and EX and owns the ID/EX
//  pipeline register. Instantiates decoder, reg_file and imm_gen internally.
//  Drives EX with registered ALU operands, store data, immediate and control flags.
// PARAMETERS
//  NUM_FWD    2  number of forwarding channels; index 0 is the youngest stage and has highest priority
//  SHAMT_MASK 1  1: for OP shifts (opcode 0110011, funct3 001/101), dat_b_o[31:5]=0; 0: no masking
// PORTS
//  clk_i             in   1            clock; all state updates on rising edge
//  rst_i             in   1            synchronous reset, active-high
//  in_valid_i        in   1            instruction_i/pc_i valid from IF
//  in_ready_o        out  1            ID accepts this cycle
//  instruction_i     in   32           instruction word
//  pc_i              in   32           instruction PC
//  flush_i           in   1            discard ID/EX contents and the current input
//  rd_i              in   5            writeback destination
//  rf_wd_i           in   32           writeback data
//  rf_we_i           in   1            writeback enable
//  fwd_valid_i       in   NUM_FWD      channel k holds a register-writing instruction
//  fwd_pending_i     in   NUM_FWD      channel k result not yet available (e.g. load in EX)
//  fwd_rd_i          in   5*NUM_FWD    channel k destination, bits [5k+4:5k]
//  fwd_dat_i         in   32*NUM_FWD   channel k result, bits [32k+31:32k]
//  out_valid_o       out  1            ID/EX register holds a valid instruction
//  out_ready_i       in   1            EX accepts this cycle
//  pc_o, imm_o       out  32 each      registered PC and immediate
//  dat_a_o, dat_b_o  out  32 each      registered ALU operands (post-mux, post-forward)
//  rs2_dat_o         out  32           registered forwarded rs2 value (store data / branch compare)
//  rs1_o, rs2_o, rd_o out 5 each       registered register indices
//  funct3_o          out  3            registered funct3
//  alu_op_o          out  4            registered ALU op
//  csr_addr_o        out  12           registered CSR address
//  ctrl_o            out  10           {is_op,lui,auipc,jal,jalr,branch,ld_mem,st_mem,misc_mem,system}
//  e_illegal_inst_o  out  1            registered illegal-instruction flag (travels with the instruction)
// BEHAVIOUR
//  - Reset: out_valid_o=0 and every registered output = 0 on the cycle after rst_i is high;
//    rst_i overrides flush_i and all handshakes.
//  - Uses: rs1 is used unless lui, auipc or jal. rs2 is used by op, branch and st_mem.
//    Register x0 never matches a forwarding source, never causes a hazard and always reads 0.
//  - Operand select per rs, in priority order: lowest k with fwd_valid_i[k] && fwd_rd_i[k]==rs;
//    then the writeback bypass (rf_we_i && rd_i==rs, same-cycle write-through); then reg_file.
//  - Hazard: a used rs whose highest-priority matching channel has fwd_pending_i[k]=1.
//    A non-pending match at a lower index masks a pending match at a higher index.
//  - ALU mux: sel_dat_a/b encoding REG=00, IMM=01, PC=10, ZERO=11. The REG path uses forwarded data.
//  - in_ready_o = !rst_i && !flush_i && !hazard && (!out_valid_o || out_ready_i). Purely combinational.
//  - Accept (in_valid_i && in_ready_o): all outputs load next edge, out_valid_o<=1. Latency is 1 cycle.
//  - Drain: out_valid_o && out_ready_i && !accept -> out_valid_o<=0. Data outputs hold their values.
//  - Stall: when out_valid_o && !out_ready_i, all outputs hold stable.
//  - Hazard with a free output register: out_valid_o<=0 (bubble) and the input is not consumed.
//  - flush_i: out_valid_o<=0 next edge and the input is dropped; data outputs are don't-care.
//  - Illegal instructions are accepted like any other and flagged. Handshake is unaffected.
// TESTING
//  1 rst_i=1 for 2 cycles -> out_valid_o=0, all outputs 0, in_ready_o=0; after release in_ready_o=1.
//  2 addi x1,x0,5 (0x00500093), pc=0x100 -> next cycle out_valid_o=1, dat_a_o=0, dat_b_o=5, rd_o=1, pc_o=0x100.
//  3 add x3,x1,x2 with fwd0{x1,0xAA} and fwd1{x1,0xBB}; writeback x2=0x7 -> dat_a_o=0xAA, dat_b_o=0x7.
//  4 fwd0{x5,pending} then sub x6,x5,x0 -> in_ready_o=0 and a bubble; pending drops -> accepted one cycle later.
//  5 out_ready_i=0 for 3 cycles while valid -> outputs stable, in_ready_o=0; flush_i=1 -> out_valid_o=0 next cycle.
//  6 sll x4,x1,x2 with x2=0x25 and SHAMT_MASK=1 -> dat_b_o=0x5; lw x1 stalls a dependent add (load-use) for one cycle.

Source files
------------

// File: rtl/stage_id_pipe.sv
// Instruction-decode stage owning the ID/EX register, with N-channel forwarding and load-use stall.
// Latency: 1 cycle from input accept to registered outputs.
// Backpressure: in_ready_o drops on flush, on a pending-operand hazard, or when EX holds a stalled instruction.
package stage_id_pkg;
  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_IMM  = 2'b01;
  localparam logic [1:0] SEL_PC   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Everything the ID/EX register carries towards EX.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] dat_a;
    logic [31:0] dat_b;
    logic [31:0] rs2_dat;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic [11:0] csr_addr;
    logic [9:0]  ctrl;
    logic        illegal;
  } id_ex_t;
endpackage

// Opcode/funct decode into control flags, ALU op, operand selects and illegal flag.
// Latency: combinational.
// Backpressure: none.
module stage_id_decoder
  import stage_id_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [9:0] ctrl,
  output logic [3:0] alu_op,
  output logic [1:0] sel_a,
  output logic [1:0] sel_b,
  output logic       illegal
);
  // Control order: {is_op,lui,auipc,jal,jalr,branch,ld_mem,st_mem,misc_mem,system}.
  always_comb begin
    ctrl    = '0;
    alu_op  = '0;
    sel_a   = SEL_ZERO;
    sel_b   = SEL_ZERO;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl[9] = 1'b1; sel_a = SEL_REG; sel_b = SEL_REG;
        alu_op  = {funct7[5], funct3};
        illegal = !((funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OPIMM: begin
        sel_a = SEL_REG; sel_b = SEL_IMM;
        alu_op  = {(funct3 == 3'b101) && funct7[5], funct3};
        illegal = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                  ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      OPC_LUI:      begin ctrl[8] = 1'b1; sel_a = SEL_ZERO; sel_b = SEL_IMM; end
      OPC_AUIPC:    begin ctrl[7] = 1'b1; sel_a = SEL_PC;   sel_b = SEL_IMM; end
      OPC_JAL:      begin ctrl[6] = 1'b1; sel_a = SEL_PC;   sel_b = SEL_IMM; end
      OPC_JALR: begin
        ctrl[5] = 1'b1; sel_a = SEL_REG; sel_b = SEL_IMM;
        illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl[4] = 1'b1; sel_a = SEL_REG; sel_b = SEL_REG;
        illegal = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        ctrl[3] = 1'b1; sel_a = SEL_REG; sel_b = SEL_IMM;
        illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        ctrl[2] = 1'b1; sel_a = SEL_REG; sel_b = SEL_IMM;
        illegal = funct3[2] || (funct3 == 3'b011);
      end
      OPC_MISC_MEM: ctrl[1] = 1'b1;
      OPC_SYSTEM:   begin ctrl[0] = 1'b1; sel_a = SEL_REG; sel_b = SEL_IMM; end
      default:      illegal = 1'b1;
    endcase
  end
endmodule

// Immediate extraction and sign extension by instruction format.
// Latency: combinational.
// Backpressure: none.
module stage_id_imm_gen
  import stage_id_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);
  // Pick the format from the opcode; formats without an immediate give 0.
  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

// 32x32 register file, x0 hardwired to zero, same-cycle write-through on reads.
// Latency: combinational read, write on next edge.
// Backpressure: none.
module stage_id_reg_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] mem [32];

  // Writeback port; writes to x0 are discarded.
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) mem[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : ((we && (wa == ra1)) ? wd : mem[ra1]);
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : ((we && (wa == ra2)) ? wd : mem[ra2]);
endmodule

module stage_id_pipe
  import stage_id_pkg::*;
#(
  parameter int NUM_FWD    = 2,
  parameter bit SHAMT_MASK = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instruction_i,
  input  logic [31:0]          pc_i,
  input  logic                 flush_i,
  input  logic [4:0]           rd_i,
  input  logic [31:0]          rf_wd_i,
  input  logic                 rf_we_i,
  input  logic [NUM_FWD-1:0]   fwd_valid_i,
  input  logic [NUM_FWD-1:0]   fwd_pending_i,
  input  logic [5*NUM_FWD-1:0] fwd_rd_i,
  input  logic [32*NUM_FWD-1:0] fwd_dat_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          pc_o,
  output logic [31:0]          imm_o,
  output logic [31:0]          dat_a_o,
  output logic [31:0]          dat_b_o,
  output logic [31:0]          rs2_dat_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [4:0]           rd_o,
  output logic [2:0]           funct3_o,
  output logic [3:0]           alu_op_o,
  output logic [11:0]          csr_addr_o,
  output logic [9:0]           ctrl_o,
  output logic                 e_illegal_inst_o
);
  logic [4:0]  rs1, rs2;
  logic [9:0]  ctrl;
  logic [3:0]  alu_op;
  logic [1:0]  sel_a, sel_b;
  logic        illegal;
  logic [31:0] imm, rf_rd1, rf_rd2;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_pend, rs2_pend;
  logic        use_rs1, use_rs2, hazard, accept;
  id_ex_t      nxt, q;

  assign rs1 = instruction_i[19:15];
  assign rs2 = instruction_i[24:20];

  stage_id_decoder u_dec (
    .opcode (instruction_i[6:0]),
    .funct3 (instruction_i[14:12]),
    .funct7 (instruction_i[31:25]),
    .ctrl   (ctrl),
    .alu_op (alu_op),
    .sel_a  (sel_a),
    .sel_b  (sel_b),
    .illegal(illegal)
  );

  stage_id_imm_gen u_imm (.instr(instruction_i), .imm(imm));

  stage_id_reg_file u_rf (
    .clk(clk_i), .we(rf_we_i), .wa(rd_i), .wd(rf_wd_i),
    .ra1(rs1), .ra2(rs2), .rd1(rf_rd1), .rd2(rf_rd2)
  );

  // Forwarding: scan from the oldest channel down so the youngest match overrides.
  always_comb begin
    rs1_val  = rf_rd1;
    rs2_val  = rf_rd2;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid_i[k] && (fwd_rd_i[5*k +: 5] == rs1) && (rs1 != 5'd0)) begin
        rs1_val  = fwd_dat_i[32*k +: 32];
        rs1_pend = fwd_pending_i[k];
      end
      if (fwd_valid_i[k] && (fwd_rd_i[5*k +: 5] == rs2) && (rs2 != 5'd0)) begin
        rs2_val  = fwd_dat_i[32*k +: 32];
        rs2_pend = fwd_pending_i[k];
      end
    end
  end

  assign use_rs1    = !(ctrl[8] || ctrl[7] || ctrl[6]);
  assign use_rs2    = ctrl[9] || ctrl[4] || ctrl[2];
  assign hazard     = (use_rs1 && rs1_pend) || (use_rs2 && rs2_pend);
  assign in_ready_o = !rst_i && !flush_i && !hazard && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // Build the next ID/EX contents: operand muxes and OP-shift amount masking.
  always_comb begin
    nxt          = '0;
    nxt.pc       = pc_i;
    nxt.imm      = imm;
    nxt.rs2_dat  = rs2_val;
    nxt.rs1      = rs1;
    nxt.rs2      = rs2;
    nxt.rd       = instruction_i[11:7];
    nxt.funct3   = instruction_i[14:12];
    nxt.alu_op   = alu_op;
    nxt.csr_addr = instruction_i[31:20];
    nxt.ctrl     = ctrl;
    nxt.illegal  = illegal;
    case (sel_a)
      SEL_REG: nxt.dat_a = rs1_val;
      SEL_IMM: nxt.dat_a = imm;
      SEL_PC:  nxt.dat_a = pc_i;
      default: nxt.dat_a = '0;
    endcase
    case (sel_b)
      SEL_REG: nxt.dat_b = rs2_val;
      SEL_IMM: nxt.dat_b = imm;
      SEL_PC:  nxt.dat_b = pc_i;
      default: nxt.dat_b = '0;
    endcase
    if (SHAMT_MASK && ctrl[9] && (instruction_i[13:12] == 2'b01)) nxt.dat_b[31:5] = '0;
  end

  // ID/EX register: load on accept, otherwise hold data and drop valid on drain or flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      q           <= '0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      q           <= nxt;
    end else if (flush_i || out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  assign pc_o             = q.pc;
  assign imm_o            = q.imm;
  assign dat_a_o          = q.dat_a;
  assign dat_b_o          = q.dat_b;
  assign rs2_dat_o        = q.rs2_dat;
  assign rs1_o            = q.rs1;
  assign rs2_o            = q.rs2;
  assign rd_o             = q.rd;
  assign funct3_o         = q.funct3;
  assign alu_op_o         = q.alu_op;
  assign csr_addr_o       = q.csr_addr;
  assign ctrl_o           = q.ctrl;
  assign e_illegal_inst_o = q.illegal;
endmodule

// File: tb/tb_stage_id_pipe.sv
// Bench for the ID stage: directed scenarios followed by randomized traffic against an instruction-level model.
// Latency: the model expects registered outputs one edge after accept.
// Backpressure: out_ready_i, flush_i, forwarding/pending channels and reset are all randomized.
module tb_stage_id_pipe;
  logic        clk_i = 1'b0;
  logic        rst_i, in_valid_i, in_ready_o, flush_i, rf_we_i, out_valid_o, out_ready_i;
  logic [31:0] instruction_i, pc_i, rf_wd_i;
  logic [4:0]  rd_i;
  logic [1:0]  fwd_valid_i, fwd_pending_i;
  logic [9:0]  fwd_rd_i;
  logic [63:0] fwd_dat_i;
  logic [31:0] pc_o, imm_o, dat_a_o, dat_b_o, rs2_dat_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  funct3_o;
  logic [3:0]  alu_op_o;
  logic [11:0] csr_addr_o;
  logic [9:0]  ctrl_o;
  logic        e_illegal_inst_o;

  logic [4:0]  frd  [2];
  logic [31:0] fdat [2];
  assign fwd_rd_i  = {frd[1], frd[0]};
  assign fwd_dat_i = {fdat[1], fdat[0]};

  always #5 clk_i = ~clk_i;

  stage_id_pipe #(.NUM_FWD(2), .SHAMT_MASK(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instruction_i(instruction_i), .pc_i(pc_i), .flush_i(flush_i),
    .rd_i(rd_i), .rf_wd_i(rf_wd_i), .rf_we_i(rf_we_i),
    .fwd_valid_i(fwd_valid_i), .fwd_pending_i(fwd_pending_i), .fwd_rd_i(fwd_rd_i), .fwd_dat_i(fwd_dat_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .imm_o(imm_o), .dat_a_o(dat_a_o), .dat_b_o(dat_b_o), .rs2_dat_o(rs2_dat_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct3_o(funct3_o), .alu_op_o(alu_op_o),
    .csr_addr_o(csr_addr_o), .ctrl_o(ctrl_o), .e_illegal_inst_o(e_illegal_inst_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  typedef enum {T_OP, T_OPI, T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_LD, T_ST, T_BAD} kind_e;
  typedef struct {
    kind_e       kind;
    logic [4:0]  rs1, rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
    logic [31:0] word;
  } ins_t;

  typedef struct packed {
    logic [31:0] pc, imm, a, b, rs2d;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [11:0] csr;
    logic [9:0]  ctrl;
    logic        ill;
  } exp_t;

  ins_t        cur;
  exp_t        m;
  bit          m_valid, m_known, last_acc;
  logic [31:0] rf_m [32];

  logic [2:0] op_f3  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
  logic       op_alt [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [2:0] opi_f3 [6]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  logic [2:0] br_f3  [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0] ld_f3  [5]  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  // Assemble an instruction word from its semantic fields.
  function automatic ins_t mk(kind_e kind, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [2:0] f3, logic alt, logic [31:0] imm);
    ins_t d;
    d.kind = kind; d.f3 = f3; d.alt = alt; d.imm = imm;
    case (kind)
      T_OP:    d.word = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
      T_OPI:   d.word = {imm[11:0], rs1, f3, rd, 7'b0010011};
      T_LUI:   d.word = {imm[31:12], rd, 7'b0110111};
      T_AUIPC: d.word = {imm[31:12], rd, 7'b0010111};
      T_JAL:   d.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      T_JALR:  d.word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      T_BR:    d.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      T_LD:    d.word = {imm[11:0], rs1, f3, rd, 7'b0000011};
      T_ST:    d.word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      default: d.word = {imm[24:0], 7'b0001011};
    endcase
    d.rs1 = d.word[19:15];
    d.rs2 = d.word[24:20];
    return d;
  endfunction

  function automatic ins_t rand_ins();
    kind_e       k = kind_e'($urandom_range(0, 9));
    logic [31:0] r = $urandom;
    logic [4:0]  rd = 5'($urandom_range(0, 7));
    logic [4:0]  a  = 5'($urandom_range(0, 7));
    logic [4:0]  b  = 5'($urandom_range(0, 7));
    int          i;
    case (k)
      T_OP:    begin i = $urandom_range(0, 9); return mk(k, rd, a, b, op_f3[i], op_alt[i], 0); end
      T_OPI:   return mk(k, rd, a, b, opi_f3[$urandom_range(0, 5)], 1'b0, {{20{r[11]}}, r[11:0]});
      T_LUI, T_AUIPC: return mk(k, rd, a, b, 3'd0, 1'b0, {r[31:12], 12'b0});
      T_JAL:   return mk(k, rd, a, b, 3'd0, 1'b0, {{11{r[20]}}, r[20:1], 1'b0});
      T_JALR:  return mk(k, rd, a, b, 3'd0, 1'b0, {{20{r[11]}}, r[11:0]});
      T_BR:    return mk(k, rd, a, b, br_f3[$urandom_range(0, 5)], 1'b0, {{19{r[12]}}, r[12:1], 1'b0});
      T_LD:    return mk(k, rd, a, b, ld_f3[$urandom_range(0, 4)], 1'b0, {{20{r[11]}}, r[11:0]});
      T_ST:    return mk(k, rd, a, b, 3'($urandom_range(0, 2)), 1'b0, {{20{r[11]}}, r[11:0]});
      default: return mk(T_BAD, rd, a, b, 3'd0, 1'b0, r);
    endcase
  endfunction

  // Operand value as seen by ID: youngest forwarding match, then writeback, then register file.
  function automatic logic [31:0] opnd_val(logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    for (int k = 0; k < 2; k++)
      if (fwd_valid_i[k] && frd[k] == r) return fdat[k];
    if (rf_we_i && rd_i == r) return rf_wd_i;
    return rf_m[r];
  endfunction

  function automatic bit opnd_pend(logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (fwd_valid_i[k] && frd[k] == r) return fwd_pending_i[k];
    return 1'b0;
  endfunction

  function automatic bit hazard_now();
    bit u1 = !(cur.kind inside {T_LUI, T_AUIPC, T_JAL});
    bit u2 = cur.kind inside {T_OP, T_BR, T_ST};
    return (u1 && opnd_pend(cur.rs1)) || (u2 && opnd_pend(cur.rs2));
  endfunction

  function automatic exp_t expect_now();
    exp_t        e = '0;
    logic [31:0] o1 = opnd_val(cur.rs1);
    logic [31:0] o2 = opnd_val(cur.rs2);
    e.pc = pc_i; e.rs2d = o2;
    e.rs1 = cur.word[19:15]; e.rs2 = cur.word[24:20]; e.rd = cur.word[11:7];
    e.f3 = cur.word[14:12]; e.csr = cur.word[31:20];
    if (!(cur.kind inside {T_OP, T_BAD})) e.imm = cur.imm;
    case (cur.kind)
      T_OP: begin
        e.ctrl = 10'h200; e.a = o1; e.alu = {cur.alt, cur.f3};
        e.b = (cur.f3 == 3'd1 || cur.f3 == 3'd5) ? (o2 & 32'h1f) : o2;
      end
      T_OPI:   begin e.a = o1; e.b = cur.imm; e.alu = {1'b0, cur.f3}; end
      T_LUI:   begin e.ctrl = 10'h100; e.b = cur.imm; end
      T_AUIPC: begin e.ctrl = 10'h080; e.a = pc_i; e.b = cur.imm; end
      T_JAL:   begin e.ctrl = 10'h040; e.a = pc_i; e.b = cur.imm; end
      T_JALR:  begin e.ctrl = 10'h020; e.a = o1; e.b = cur.imm; end
      T_BR:    begin e.ctrl = 10'h010; e.a = o1; e.b = o2; end
      T_LD:    begin e.ctrl = 10'h008; e.a = o1; e.b = cur.imm; end
      T_ST:    begin e.ctrl = 10'h004; e.a = o1; e.b = cur.imm; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic set_ins(ins_t d);
    cur = d;
    instruction_i = d.word;
  endtask

  task automatic idle();
    in_valid_i = 0; flush_i = 0; out_ready_i = 1; rf_we_i = 0; rd_i = 0; rf_wd_i = 0;
    fwd_valid_i = 0; fwd_pending_i = 0;
    for (int k = 0; k < 2; k++) begin frd[k] = 0; fdat[k] = 0; end
    pc_i = 0;
    set_ins(mk(T_OPI, 0, 0, 0, 3'd0, 1'b0, 0));
  endtask

  // One clock: check ready before the edge, advance the model at the edge, check outputs after it.
  task automatic step();
    exp_t e;
    bit   rdy;
    #1;
    rdy = !rst_i && !flush_i && !hazard_now() && (!m_valid || out_ready_i);
    chk("in_ready", in_ready_o, rdy);
    e = expect_now();
    @(posedge clk_i);
    last_acc = in_valid_i && rdy;
    if (rst_i)         begin m_valid = 0; m = '0; m_known = 1; end
    else if (last_acc) begin m_valid = 1; m = e;  m_known = 1; end
    else if (flush_i)  begin m_valid = 0; m_known = 0; end
    else if (out_ready_i) m_valid = 0;
    if (rf_we_i && rd_i != 5'd0) rf_m[rd_i] = rf_wd_i;
    #1;
    chk("out_valid", out_valid_o, m_valid);
    if (m_known) begin
      chk("pc", pc_o, m.pc);           chk("imm", imm_o, m.imm);
      chk("dat_a", dat_a_o, m.a);      chk("dat_b", dat_b_o, m.b);
      chk("rs2_dat", rs2_dat_o, m.rs2d);
      chk("rs1", rs1_o, m.rs1);        chk("rs2", rs2_o, m.rs2);
      chk("rd", rd_o, m.rd);           chk("funct3", funct3_o, m.f3);
      chk("alu_op", alu_op_o, m.alu);  chk("csr", csr_addr_o, m.csr);
      chk("ctrl", ctrl_o, m.ctrl);     chk("illegal", e_illegal_inst_o, m.ill);
    end
    @(negedge clk_i);
  endtask

  initial begin
    bit hold = 0;
    m = '0; m_valid = 0; m_known = 0; last_acc = 0;
    for (int r = 0; r < 32; r++) rf_m[r] = 0;
    idle();
    rst_i = 1;
    @(negedge clk_i);
    step(); step();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_dat_a", dat_a_o, 0);
    rst_i = 0;
    #1 chk("rdy_after_rst", in_ready_o, 1);
    for (int r = 1; r < 32; r++) begin
      rf_we_i = 1; rd_i = 5'(r); rf_wd_i = $urandom; step();
    end
    idle();

    // addi x1,x0,5 at pc 0x100
    set_ins(mk(T_OPI, 1, 0, 0, 3'd0, 1'b0, 5)); pc_i = 32'h100; in_valid_i = 1;
    chk("t2_word", instruction_i, 32'h0050_0093);
    step();
    chk("t2_valid", out_valid_o, 1); chk("t2_a", dat_a_o, 0); chk("t2_b", dat_b_o, 5);
    chk("t2_rd", rd_o, 1); chk("t2_pc", pc_o, 32'h100);

    // add x3,x1,x2: youngest forward wins, x2 via writeback bypass
    set_ins(mk(T_OP, 3, 1, 2, 3'd0, 1'b0, 0));
    fwd_valid_i = 2'b11; frd[0] = 1; fdat[0] = 32'hAA; frd[1] = 1; fdat[1] = 32'hBB;
    rf_we_i = 1; rd_i = 2; rf_wd_i = 32'h7;
    step();
    chk("t3_a", dat_a_o, 32'hAA); chk("t3_b", dat_b_o, 32'h7);
    idle();

    // pending producer on x5 stalls sub x6,x5,x0 until it resolves
    fwd_valid_i = 2'b01; fwd_pending_i = 2'b01; frd[0] = 5;
    set_ins(mk(T_OP, 6, 5, 0, 3'd0, 1'b1, 0)); in_valid_i = 1;
    #1 chk("t4_rdy", in_ready_o, 0);
    step();
    chk("t4_bubble", out_valid_o, 0);
    fwd_pending_i = 2'b00; fdat[0] = 32'h55;
    step();
    chk("t4_acc", out_valid_o, 1); chk("t4_a", dat_a_o, 32'h55); chk("t4_alu", alu_op_o, 4'h8);
    idle();

    // hold under EX backpressure, then flush
    set_ins(mk(T_OPI, 7, 0, 0, 3'd0, 1'b0, 32'h12)); in_valid_i = 1;
    step();
    set_ins(mk(T_OPI, 8, 0, 0, 3'd0, 1'b0, 32'h34)); out_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_rdy", in_ready_o, 0);
      step();
      chk("t5_hold_v", out_valid_o, 1); chk("t5_hold_b", dat_b_o, 32'h12);
    end
    flush_i = 1;
    step();
    chk("t5_flush", out_valid_o, 0);
    idle();

    // sll shift amount masking, then load-use stall
    set_ins(mk(T_OP, 4, 1, 2, 3'd1, 1'b0, 0)); rf_we_i = 1; rd_i = 2; rf_wd_i = 32'h25; in_valid_i = 1;
    step();
    chk("t6_shamt", dat_b_o, 32'h5);
    rf_we_i = 0;
    set_ins(mk(T_LD, 1, 3, 0, 3'd2, 1'b0, 8));
    step();
    chk("t6_ld_ctrl", ctrl_o, 10'h008);
    set_ins(mk(T_OP, 7, 1, 1, 3'd0, 1'b0, 0));
    fwd_valid_i = 2'b01; fwd_pending_i = 2'b01; frd[0] = 1;
    step();
    chk("t6_stall", out_valid_o, 0);
    fwd_valid_i = 2'b10; fwd_pending_i = 2'b00; frd[1] = 1; fdat[1] = 32'hCAFE;
    step();
    chk("t6_go", out_valid_o, 1); chk("t6_a", dat_a_o, 32'hCAFE); chk("t6_b", dat_b_o, 32'hCAFE);

    // x0 never matches a pending forward
    fwd_valid_i = 2'b01; fwd_pending_i = 2'b01; frd[0] = 0; fdat[0] = 32'hDEAD;
    set_ins(mk(T_OP, 9, 0, 0, 3'd0, 1'b0, 0));
    step();
    chk("x0_valid", out_valid_o, 1); chk("x0_a", dat_a_o, 0);

    // ready younger match masks an older pending one
    fwd_valid_i = 2'b11; fwd_pending_i = 2'b10; frd[0] = 5; fdat[0] = 32'h11; frd[1] = 5;
    set_ins(mk(T_OP, 6, 5, 5, 3'd0, 1'b1, 0));
    step();
    chk("mask_valid", out_valid_o, 1); chk("mask_a", dat_a_o, 32'h11);
    idle();
    step();

    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 299) == 0);
      if (!hold) begin
        set_ins(rand_ins());
        pc_i = $urandom & 32'hFFFF_FFFC;
      end
      in_valid_i  = hold ? 1'b1 : ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 7);
      flush_i     = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 2; k++) begin
        fwd_valid_i[k]   = $urandom_range(0, 1);
        fwd_pending_i[k] = ($urandom_range(0, 3) == 0);
        frd[k]  = 5'($urandom_range(0, 7));
        fdat[k] = $urandom;
      end
      rf_we_i = $urandom_range(0, 1);
      rd_i    = 5'($urandom_range(0, 7));
      rf_wd_i = $urandom;
      step();
      hold = in_valid_i && !last_acc && !flush_i && !rst_i;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
